// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_pending_ctrl
// Description : 8-line interrupt pending register with fixed-priority offer,
//               ready/valid acceptance and EOI-terminated service phase.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_pending_ctrl #(
    parameter int LEVEL_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_in,
    input  logic [7:0] mask_in,
    input  logic       irq_ready,
    input  logic       eoi_in,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] pending_out,
    output logic       busy_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OFFER   = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [1:0] r_state;
    logic [7:0] r_pending;
    logic [7:0] r_prev;
    logic [2:0] r_id;

    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic [7:0] w_eligible;
    logic       w_accept;
    logic [2:0] w_top;

    always_comb begin
        w_set      = (LEVEL_MODE != 0) ? irq_in : (irq_in & ~r_prev);
        w_accept   = (r_state == S_OFFER) && irq_ready;
        w_clr      = w_accept ? (8'd1 << r_id) : 8'd0;
        w_eligible = r_pending & mask_in;
        // Ascending scan: the last hit is the highest-priority line.
        w_top      = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_eligible[i]) begin
                w_top = 3'(i);
            end
        end
    end

    // The previous-sample register tracks irq_in even during reset so a line
    // held high across reset release is not seen as a fresh edge.
    always_ff @(posedge clk) begin
        r_prev <= irq_in;
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= 8'h00;
            r_id      <= 3'd0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            case (r_state)
                S_IDLE: begin
                    if (w_eligible != 8'h00) begin
                        r_state <= S_OFFER;
                        r_id    <= w_top;
                    end
                end
                S_OFFER: begin
                    if (irq_ready) begin
                        r_state <= S_SERVICE;
                        r_id    <= 3'd0;
                    end
                end
                S_SERVICE: begin
                    if (eoi_in) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_id    <= 3'd0;
                end
            endcase
        end
    end

    assign irq_valid   = (r_state == S_OFFER);
    assign busy_out    = (r_state == S_SERVICE);
    assign irq_id      = r_id;
    assign pending_out = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_pending_ctrl
// Description : Self-checking bench for irq_pending_ctrl (edge and level mode).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst, irq_ready, eoi_in;
    logic [7:0] irq_in, mask_in;
    logic       irq_valid, busy_out;
    logic [2:0] irq_id;
    logic [7:0] pending_out;

    logic       lrst, lready, leoi;
    logic [7:0] lirq, lmask;
    logic       lvalid, lbusy;
    logic [2:0] lid;
    logic [7:0] lpend;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    irq_pending_ctrl #(.LEVEL_MODE(0)) u_edge (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_in(mask_in),
        .irq_ready(irq_ready), .eoi_in(eoi_in), .irq_valid(irq_valid),
        .irq_id(irq_id), .pending_out(pending_out), .busy_out(busy_out)
    );

    irq_pending_ctrl #(.LEVEL_MODE(1)) u_level (
        .clk(clk), .rst(lrst), .irq_in(lirq), .mask_in(lmask),
        .irq_ready(lready), .eoi_in(leoi), .irq_valid(lvalid),
        .irq_id(lid), .pending_out(lpend), .busy_out(lbusy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted offer must match the next queued ID.
    always @(negedge clk) begin
        if (!rst && irq_valid && irq_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected_accept", {29'd0, irq_id}, 32'hFFFF_FFFF);
            else                   chk("sb_offer_id", {29'd0, irq_id}, {29'd0, exp_q.pop_front()});
        end
    end

    task automatic wait_valid(input int max_cyc);
        int n = 0;
        while (!irq_valid && n < max_cyc) begin
            tick();
            n++;
        end
        chk("offer_timeout", irq_valid, 1'b1);
    endtask

    task automatic serve(input logic [7:0] exp_pend);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        chk("acc_busy", busy_out, 1'b1);
        chk("acc_valid", irq_valid, 1'b0);
        chk("acc_id_zero", irq_id, 3'd0);
        chk("acc_pend", pending_out, exp_pend);
        eoi_in = 1'b1;
        tick();
        eoi_in = 1'b0;
        chk("eoi_busy", busy_out, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq_in = 8'hFF; mask_in = 8'hFF; irq_ready = 1'b0; eoi_in = 1'b0;
        lrst = 1'b1; lirq = 8'h00; lmask = 8'hFF; lready = 1'b0; leoi = 1'b0;

        // Reset with all lines held high, then release: no edge seen.
        tick(); tick();
        chk("rst_pend", pending_out, 8'h00);
        chk("rst_valid", irq_valid, 1'b0);
        chk("rst_id", irq_id, 3'd0);
        chk("rst_busy", busy_out, 1'b0);
        rst = 1'b0;
        tick(); tick();
        chk("rel_pend", pending_out, 8'h00);
        chk("rel_valid", irq_valid, 1'b0);
        irq_in = 8'h00;
        tick();

        // Single line, edge latency; line stays high through service.
        irq_in = 8'h20; exp_q.push_back(3'd5);
        tick();
        chk("a_pend_k", pending_out, 8'h20);
        chk("a_valid_k", irq_valid, 1'b0);
        tick();
        chk("a_valid_k1", irq_valid, 1'b1);
        chk("a_id_k1", irq_id, 3'd5);
        serve(8'h00);
        tick();
        chk("a_no_retrigger", pending_out, 8'h00);
        chk("a_idle_valid", irq_valid, 1'b0);
        irq_in = 8'h00;
        tick();

        // Three simultaneous lines served in priority order.
        irq_in = 8'h91;
        exp_q.push_back(3'd7); exp_q.push_back(3'd4); exp_q.push_back(3'd0);
        tick();
        chk("b_pend", pending_out, 8'h91);
        irq_in = 8'h00;
        tick();
        chk("b_id7", irq_id, 3'd7);
        serve(8'h11);
        wait_valid(4);
        chk("b_id4", irq_id, 3'd4);
        serve(8'h01);
        wait_valid(4);
        chk("b_id0", irq_id, 3'd0);
        serve(8'h00);
        tick();

        // Offer held without ready; higher line arrives; EOI ignored in OFFER.
        irq_in = 8'h04; exp_q.push_back(3'd2);
        tick();
        irq_in = 8'h00;
        tick();
        chk("c_id2", irq_id, 3'd2);
        irq_in = 8'h40; exp_q.push_back(3'd6);
        tick();
        irq_in = 8'h00;
        eoi_in = 1'b1;
        tick();
        eoi_in = 1'b0;
        tick();
        chk("c_hold_valid", irq_valid, 1'b1);
        chk("c_hold_id", irq_id, 3'd2);
        chk("c_pend", pending_out, 8'h44);
        serve(8'h40);
        wait_valid(4);
        chk("c_id6", irq_id, 3'd6);
        serve(8'h00);
        tick();

        // Masked line latches but is not offered until unmasked.
        mask_in = 8'h0F;
        irq_in = 8'h80; exp_q.push_back(3'd7);
        tick();
        irq_in = 8'h00;
        tick(); tick(); tick();
        chk("d_pend", pending_out, 8'h80);
        chk("d_masked_valid", irq_valid, 1'b0);
        mask_in = 8'hFF;
        tick();
        chk("d_valid", irq_valid, 1'b1);
        chk("d_id7", irq_id, 3'd7);
        serve(8'h00);
        tick();

        // Accept and new edge on the same line at the same clock edge.
        irq_in = 8'h08; exp_q.push_back(3'd3);
        tick();
        irq_in = 8'h00;
        tick();
        chk("e_id3", irq_id, 3'd3);
        irq_in = 8'h08; irq_ready = 1'b1; exp_q.push_back(3'd3);
        tick();
        irq_ready = 1'b0; irq_in = 8'h00;
        chk("e_set_wins", pending_out, 8'h08);
        chk("e_busy", busy_out, 1'b1);
        eoi_in = 1'b1;
        tick();
        eoi_in = 1'b0;
        wait_valid(4);
        chk("e_reoffer", irq_id, 3'd3);
        serve(8'h00);
        tick();

        // Reset during OFFER.
        irq_in = 8'h10;
        tick();
        irq_in = 8'h00;
        tick();
        chk("f_offer", irq_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("f_rst_offer_valid", irq_valid, 1'b0);
        chk("f_rst_offer_pend", pending_out, 8'h00);
        chk("f_rst_offer_id", irq_id, 3'd0);

        // Reset during SERVICE with another line pending.
        irq_in = 8'h02; exp_q.push_back(3'd1);
        tick();
        irq_in = 8'h00;
        tick();
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        chk("f_svc_busy", busy_out, 1'b1);
        chk("f_svc_pend", pending_out, 8'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("f_rst_svc_busy", busy_out, 1'b0);
        chk("f_rst_svc_pend", pending_out, 8'h00);
        tick();
        chk("f_after_valid", irq_valid, 1'b0);

        // Level mode: held line keeps re-setting its pending bit.
        lirq = 8'h08;
        tick();
        chk("l_rst_pend", lpend, 8'h00);
        lrst = 1'b0;
        tick();
        chk("l_pend", lpend, 8'h08);
        tick();
        chk("l_valid", lvalid, 1'b1);
        chk("l_id", lid, 3'd3);
        lready = 1'b1;
        tick();
        lready = 1'b0;
        chk("l_busy", lbusy, 1'b1);
        chk("l_pend_held", lpend, 8'h08);
        lirq = 8'h00; leoi = 1'b1;
        tick();
        leoi = 1'b0;
        tick();
        chk("l_reoffer", lvalid, 1'b1);
        lready = 1'b1;
        tick();
        lready = 1'b0;
        chk("l_cleared", lpend, 8'h00);

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 The block SHALL have parameter LEVEL_MODE, default 0: 0 = capture rising edges of request inputs, 1 = treat request inputs as level-sensitive.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: irq_in  input  8  request lines; bit 7 is highest priority, bit 0 is lowest.
REQ-006 Port: mask_in  input  8  per-line enable; 1 = line may be offered.
REQ-007 Port: irq_ready  input  1  consumer accepts the offered request.
REQ-008 Port: eoi_in  input  1  single-cycle end-of-interrupt pulse from the consumer.
REQ-009 Port: irq_valid  output  1  a request ID is being offered.
REQ-010 Port: irq_id  output  3  offered line index (7..0), registered.
REQ-011 Port: pending_out  output  8  current pending register.
REQ-012 Port: busy_out  output  1  a request is in service (accepted, EOI not yet seen).

Function
REQ-013 Edge mode: a pending bit SHALL be set at clock edge k when irq_in[i]=1 at edge k and was 0 at edge k-1.
REQ-014 Level mode: a pending bit SHALL be set at every edge where irq_in[i]=1.
REQ-015 Pending bits SHALL latch regardless of mask_in; masking only blocks offering.
REQ-016 Pending bits SHALL clear only when the offered request is accepted.
REQ-017 Acceptance SHALL be defined as irq_valid=1 and irq_ready=1 at a clock edge.
REQ-018 If a set condition and an accept-clear hit the same bit at the same edge, the set SHALL win and the bit stays 1.
REQ-019 The block SHALL implement an FSM with states IDLE, OFFER and SERVICE.
REQ-020 IDLE -> OFFER SHALL occur at an edge where (pending & mask_in) != 0; irq_id SHALL load the index of the highest set bit of (pending & mask_in) at that same edge.
REQ-021 OFFER SHALL drive irq_valid=1.
REQ-022 In OFFER, irq_id SHALL hold stable until acceptance, with no re-arbitration, even if a higher-priority line becomes pending or the offered line becomes masked.
REQ-023 OFFER -> SERVICE SHALL occur on acceptance; at that same edge, pending[irq_id] is cleared, irq_valid drops and busy_out rises.
REQ-024 SERVICE -> IDLE SHALL occur at an edge with eoi_in=1; busy_out then drops.
REQ-025 eoi_in SHALL be ignored in IDLE and OFFER.
REQ-026 irq_id SHALL read 3'b000 whenever irq_valid=0; outputs SHALL never be high-impedance.
REQ-027 Latency: a rising edge sampled at edge k SHALL give pending_out at edge k and irq_valid=1 after edge k+1 (IDLE, unmasked).
REQ-028 Minimum spacing between two consecutive offers SHALL be: accept, EOI, then one cycle in IDLE.
REQ-029 pending_out SHALL reflect the pending register directly.
REQ-030 busy_out SHALL be 1 exactly in SERVICE.

Reset
REQ-031 At an edge with rst=1, the block SHALL set FSM=IDLE, pending=8'h00, irq_valid=0, irq_id=3'b000 and busy_out=0.
REQ-032 During rst=1, the previous-sample register SHALL load irq_in, so a line held high through reset release produces no edge in edge mode.
REQ-033 Reset asserted in OFFER or SERVICE SHALL abort the request within that edge, with no pending bit retained.

Verification
REQ-034 Scenario: edge mode, mask=8'hFF, pulse irq_in[5] for 1 cycle at edge k -> pending_out=8'h20 after edge k; irq_valid=1 and irq_id=5 after edge k+1.
REQ-035 Scenario: irq_in=8'b1001_0001 rising together, mask=8'hFF -> offers in order 7, 4, 0, each requiring ready and then eoi; pending_out goes 8'h91 -> 8'h11 -> 8'h01 -> 8'h00.
REQ-036 Scenario: offer id=2 held with irq_ready=0, then irq_in[6] rises -> irq_id stays 2 until acceptance; the next offer is 6.
REQ-037 Scenario: mask=8'h0F, irq_in[7] rises -> pending_out=8'h80 and irq_valid stays 0; setting mask[7]=1 -> offer id=7 one cycle later.
REQ-038 Scenario: offered id=3 is accepted at the same edge that irq_in[3] produces a new rising edge -> pending_out[3] remains 1 and id 3 is re-offered after EOI.
REQ-039 Scenario: irq_in=8'hFF held through rst=1 then release, edge mode -> pending_out=8'h00 and irq_valid=0; rst asserted in SERVICE -> busy_out=0 after the reset edge.
